// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// reset PC default and PC alignment helper.
package pc_fetch_unit_pkg;

  typedef enum logic [1:0] {
    FS_FETCH = 2'd0,
    FS_WAIT  = 2'd1,
    FS_HOLD  = 2'd2,
    FS_DRAIN = 2'd3
  } fs_t;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

  // Redirect targets are forced to word alignment; misalignment is not flagged.
  function automatic logic [31:0] align_pc(input logic [31:0] a);
    return a & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/pc_fetch_unit.sv
// Program counter owner and single-outstanding instruction fetcher with
// redirect handling, stale-response draining and a handoff counter.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [31:0]      imem_rdata,
  output logic             instr_valid,
  output logic [31:0]      instr,
  output logic [31:0]      instr_pc,
  input  logic             out_ready,
  output logic [CNT_W-1:0] fetch_cnt
);

  fs_t         state, state_nx;
  logic [31:0] pc;
  logic        granted;
  logic        capture;
  logic        accept;
  logic        release_hold;

  assign imem_addr = pc;
  assign granted   = imem_req & imem_gnt;

  always_ff @(posedge clk) begin
    if (rst) state <= FS_FETCH;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      FS_FETCH: if (granted) state_nx = redirect_valid ? FS_DRAIN : FS_WAIT;
      FS_WAIT: begin
        if (imem_rvalid)         state_nx = redirect_valid ? FS_FETCH : FS_HOLD;
        else if (redirect_valid) state_nx = FS_DRAIN;
      end
      FS_HOLD:  if (redirect_valid || (out_ready && !stall)) state_nx = FS_FETCH;
      // The drained response always ends DRAIN, even alongside a fresh redirect,
      // since no further response is outstanding.
      FS_DRAIN: if (imem_rvalid) state_nx = FS_FETCH;
      default:  state_nx = FS_FETCH;
    endcase
  end

  always_comb begin
    imem_req     = (state == FS_FETCH) && !stall && !rst;
    capture      = (state == FS_WAIT) && imem_rvalid && !redirect_valid;
    accept       = (state == FS_HOLD) && !redirect_valid && out_ready && !stall;
    release_hold = (state == FS_HOLD) && (redirect_valid || (out_ready && !stall));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      fetch_cnt   <= '0;
    end else begin
      if (redirect_valid) pc <= align_pc(redirect_pc);
      else if (capture)   pc <= pc + 32'd4;

      if (capture) begin
        instr       <= imem_rdata;
        instr_pc    <= pc;
        instr_valid <= 1'b1;
      end else if (release_hold) begin
        instr_valid <= 1'b0;
      end

      if (accept) fetch_cnt <= fetch_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed table, hand sequences for
// redirect/stall/wrap/reset corners, and randomized traffic vs a reference model.
module tb_pc_fetch_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        out_ready;
  logic [31:0] fetch_cnt;

  pc_fetch_unit #(.RESET_PC(32'h0000_3000), .CNT_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .out_ready     (out_ready),
    .fetch_cnt     (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: transaction-level view (one outstanding request,
  // possibly stale; one instruction held for decode).
  logic [31:0] m_pc;
  logic        m_pend;
  logic        m_stale;
  logic        m_hold;
  logic [31:0] m_instr;
  logic [31:0] m_ipc;
  logic [31:0] m_cnt;

  task automatic m_reset();
    m_pc = 32'h0000_3000; m_pend = 0; m_stale = 0; m_hold = 0;
    m_instr = 0; m_ipc = 0; m_cnt = 0;
  endtask

  function automatic logic m_req();
    return !rst && !stall && !m_pend && !m_hold;
  endfunction

  task automatic m_step();
    logic [31:0] tgt;
    tgt = {redirect_pc[31:2], 2'b00};
    if (rst) begin
      m_reset();
    end else if (m_hold) begin
      if (redirect_valid) begin
        m_hold = 0; m_pc = tgt;
      end else if (out_ready && !stall) begin
        m_hold = 0; m_cnt = m_cnt + 1;
      end
    end else if (m_pend) begin
      if (imem_rvalid) begin
        m_pend = 0;
        if (!m_stale && !redirect_valid) begin
          m_hold = 1; m_instr = imem_rdata; m_ipc = m_pc; m_pc = m_pc + 4;
        end
        if (redirect_valid) m_pc = tgt;
      end else if (redirect_valid) begin
        m_stale = 1; m_pc = tgt;
      end
    end else begin
      if (m_req() && imem_gnt) begin
        m_pend = 1; m_stale = redirect_valid;
      end
      if (redirect_valid) m_pc = tgt;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs (at the falling edge) and compare against the model.
  task automatic apply(input logic r, input logic s, input logic rdv, input logic [31:0] rpc,
                       input logic g, input logic rv, input logic [31:0] rd, input logic rdy);
    rst = r; stall = s; redirect_valid = rdv; redirect_pc = rpc;
    imem_gnt = g; imem_rvalid = rv; imem_rdata = rd; out_ready = rdy;
    #1;
    check("model_req", {31'b0, imem_req}, {31'b0, m_req()});
    check("model_addr", imem_addr, m_pc);
    check("model_valid", {31'b0, instr_valid}, {31'b0, m_hold});
    check("model_cnt", fetch_cnt, m_cnt);
    if (m_hold) begin
      check("model_instr", instr, m_instr);
      check("model_ipc", instr_pc, m_ipc);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    m_step();
    @(negedge clk);
  endtask

  typedef struct {
    logic        stall;
    logic        gnt;
    logic        rv;
    logic [31:0] rd;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_ipc;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t tbl[10];

  int lat;
  logic g, rv;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b0, 1'b1, 1'b0, 32'h0,          1'b1, 1'b1, 32'h3000, 1'b0, 32'h0,          32'h0,    32'd0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 32'h0000_0013,  1'b1, 1'b0, 32'h3000, 1'b0, 32'h0,          32'h0,    32'd0};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 32'h0,          1'b1, 1'b0, 32'h3004, 1'b1, 32'h0000_0013,  32'h3000, 32'd0};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 32'h0,          1'b1, 1'b1, 32'h3004, 1'b0, 32'h0,          32'h0,    32'd1};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 32'h0010_0093,  1'b1, 1'b0, 32'h3004, 1'b0, 32'h0,          32'h0,    32'd1};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 32'h0,          1'b1, 1'b0, 32'h3008, 1'b1, 32'h0010_0093,  32'h3004, 32'd1};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 32'h0,          1'b1, 1'b1, 32'h3008, 1'b0, 32'h0,          32'h0,    32'd2};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 32'h0020_0113,  1'b1, 1'b0, 32'h3008, 1'b0, 32'h0,          32'h0,    32'd2};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 32'h0,          1'b1, 1'b0, 32'h300C, 1'b1, 32'h0020_0113,  32'h3008, 32'd2};
    tbl[9] = '{1'b1, 1'b0, 1'b0, 32'h0,          1'b1, 1'b0, 32'h300C, 1'b0, 32'h0,          32'h0,    32'd3};

    rst = 1; stall = 0; redirect_valid = 0; redirect_pc = 0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0; out_ready = 0;
    m_reset();
    @(posedge clk);
    @(negedge clk);
    apply(1, 0, 0, 0, 0, 0, 0, 0);
    advance();
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_ipc", instr_pc, 32'd0);
    check("rst_cnt", fetch_cnt, 32'd0);
    check("rst_addr", imem_addr, 32'h3000);

    // Free-run table
    for (int i = 0; i < 10; i++) begin
      apply(0, tbl[i].stall, 0, 0, tbl[i].gnt, tbl[i].rv, tbl[i].rd, tbl[i].rdy);
      check($sformatf("tbl%0d_req", i), {31'b0, imem_req}, {31'b0, tbl[i].e_req});
      check($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].e_addr);
      check($sformatf("tbl%0d_valid", i), {31'b0, instr_valid}, {31'b0, tbl[i].e_valid});
      check($sformatf("tbl%0d_cnt", i), fetch_cnt, tbl[i].e_cnt);
      if (tbl[i].e_valid) begin
        check($sformatf("tbl%0d_instr", i), instr, tbl[i].e_instr);
        check($sformatf("tbl%0d_ipc", i), instr_pc, tbl[i].e_ipc);
      end
      advance();
    end

    // Redirect in WAIT, stale response arrives two cycles later
    apply(0, 0, 0, 0, 1, 0, 0, 1); advance();
    apply(0, 0, 1, 32'h0000_4001, 0, 0, 0, 1); advance();
    apply(0, 0, 0, 0, 0, 0, 0, 1);
    check("drain_req", {31'b0, imem_req}, 32'd0);
    advance();
    apply(0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF, 1); advance();
    apply(0, 0, 0, 0, 0, 0, 0, 1);
    check("drop_valid", {31'b0, instr_valid}, 32'd0);
    check("redir_req", {31'b0, imem_req}, 32'd1);
    check("redir_addr", imem_addr, 32'h4000);
    advance();
    apply(0, 0, 0, 0, 0, 0, 0, 1);
    check("drop_valid2", {31'b0, instr_valid}, 32'd0);

    // Redirect coincident with rvalid in WAIT
    apply(0, 0, 0, 0, 1, 0, 0, 1); advance();
    apply(0, 0, 1, 32'h0000_5000, 0, 1, 32'h1111_2222, 1); advance();
    apply(0, 0, 0, 0, 0, 0, 0, 1);
    check("coin_valid", {31'b0, instr_valid}, 32'd0);
    check("coin_req", {31'b0, imem_req}, 32'd1);
    check("coin_addr", imem_addr, 32'h5000);

    // HOLD under backpressure, then stall
    apply(0, 0, 0, 0, 1, 0, 0, 0); advance();
    apply(0, 0, 0, 0, 0, 1, 32'hCAFE_F00D, 0); advance();
    for (int i = 0; i < 6; i++) begin
      if (i < 4) apply(0, 0, 0, 0, 0, 0, 0, 0);
      else       apply(0, 1, 0, 0, 0, 0, 0, 1);
      check("hold_valid", {31'b0, instr_valid}, 32'd1);
      check("hold_instr", instr, 32'hCAFE_F00D);
      check("hold_ipc", instr_pc, 32'h5000);
      check("hold_req", {31'b0, imem_req}, 32'd0);
      check("hold_cnt", fetch_cnt, 32'd3);
      advance();
    end
    apply(0, 0, 0, 0, 0, 0, 0, 1); advance();
    check("release_cnt", fetch_cnt, 32'd4);

    // PC wrap at top of address space
    apply(0, 1, 1, 32'hFFFF_FFFC, 0, 0, 0, 1); advance();
    apply(0, 0, 0, 0, 1, 0, 0, 1); advance();
    apply(0, 0, 0, 0, 0, 1, 32'h0000_1234, 1); advance();
    apply(0, 0, 0, 0, 0, 0, 0, 1);
    check("wrap_ipc", instr_pc, 32'hFFFF_FFFC);
    advance();
    apply(0, 0, 0, 0, 0, 0, 0, 1);
    check("wrap_addr", imem_addr, 32'h0000_0000);
    check("wrap_req", {31'b0, imem_req}, 32'd1);
    check("wrap_cnt", fetch_cnt, 32'd5);

    // Reset in WAIT
    imem_gnt = 1; #1; advance();
    apply(1, 0, 0, 0, 0, 0, 0, 1);
    check("rstw_req", {31'b0, imem_req}, 32'd0);
    advance();
    apply(0, 0, 0, 0, 0, 0, 0, 1);
    check("rstw_valid", {31'b0, instr_valid}, 32'd0);
    check("rstw_addr", imem_addr, 32'h3000);
    check("rstw_cnt", fetch_cnt, 32'd0);
    check("rstw_req1", {31'b0, imem_req}, 32'd1);

    // Reset in HOLD
    imem_gnt = 1; #1; advance();
    apply(0, 0, 0, 0, 0, 1, 32'h0BAD_0BAD, 0); advance();
    apply(1, 0, 0, 0, 0, 0, 0, 0);
    check("rsth_pre_valid", {31'b0, instr_valid}, 32'd1);
    advance();
    apply(0, 0, 0, 0, 0, 0, 0, 1);
    check("rsth_valid", {31'b0, instr_valid}, 32'd0);
    check("rsth_addr", imem_addr, 32'h3000);
    check("rsth_cnt", fetch_cnt, 32'd0);
    check("rsth_req1", {31'b0, imem_req}, 32'd1);
    advance();

    // Randomized traffic against the reference model
    lat = 0;
    for (int i = 0; i < 2000; i++) begin
      logic s, rdv, rdy;
      logic [31:0] rpc;
      s   = ($urandom % 5) == 0;
      rdv = ($urandom % 8) == 0;
      rpc = $urandom;
      rdy = ($urandom % 3) != 0;
      stall = s; rst = 0;
      g  = m_req() && (($urandom % 4) != 0);
      rv = (lat == 1) || (lat == 0 && !m_pend && ($urandom % 10) == 0);
      apply(0, s, rdv, rpc, g, rv, $urandom, rdy);
      advance();
      if (lat > 0) lat--;
      if (g) lat = $urandom_range(1, 3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Owns the architectural program counter and fetches one instruction at a time from instruction memory.
- Uses a request/grant/response handshake to memory.
- Receives the next-PC result from the branch/jump logic as a redirect (target address plus valid strobe).
- Presents each fetched instruction and its PC to decode through a valid/ready output.
- Supports pipeline stall and discards in-flight fetches made stale by a redirect.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- CNT_W, 32, width of the retired-fetch performance counter.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  pipeline stall: blocks new requests and output acceptance.
- redirect_valid  in  1  next-PC override strobe (taken branch or jump).
- redirect_pc  in  32  target PC; bits [1:0] are ignored and forced to 0.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address, word-aligned.
- imem_gnt  in  1  memory accepted the request this cycle.
- imem_rvalid  in  1  response data valid.
- imem_rdata  in  32  instruction word.
- instr_valid  out  1  held instruction is valid.
- instr  out  32  instruction word.
- instr_pc  out  32  PC of the held instruction.
- out_ready  in  1  decode consumes the instruction.
- fetch_cnt  out  CNT_W  count of instructions handed to decode.

Behaviour:
- Reset (synchronous, active-high, highest priority):
  - pc=RESET_PC, state=FETCH.
  - instr_valid=0, instr=0, instr_pc=0, fetch_cnt=0.
  - imem_req=0 during the reset cycle.
  - Reset mid-transaction abandons the transaction; the next response is not tracked, and memory is required to be reset together with this block.
- States: FETCH, WAIT, HOLD, DRAIN. At most one outstanding request.
- imem_req=1 only in FETCH with stall=0 and rst=0. imem_addr=pc at all times.
- FETCH:
  - redirect_valid with imem_gnt: pc<=redirect_pc, go to DRAIN (that response is stale).
  - redirect_valid without imem_gnt: pc<=redirect_pc, stay in FETCH.
  - imem_gnt otherwise: go to WAIT.
- WAIT:
  - imem_rvalid with no redirect: instr<=imem_rdata, instr_pc<=pc, pc<=pc+4 (wraps mod 2^32), instr_valid<=1, go to HOLD.
  - imem_rvalid with redirect in the same cycle: data discarded, pc<=redirect_pc, go to FETCH.
  - redirect without rvalid: pc<=redirect_pc, go to DRAIN.
- HOLD:
  - out_ready=1 and stall=0: instr_valid<=0, fetch_cnt<=fetch_cnt+1 (wraps), go to FETCH.
  - redirect_valid (takes priority over acceptance): instr_valid<=0, pc<=redirect_pc, no count, go to FETCH.
  - Otherwise hold; instr and instr_pc stay stable while instr_valid=1.
- DRAIN:
  - Waits for imem_rvalid, discards the data, then goes to FETCH.
  - A further redirect updates pc and stays in DRAIN.
- Latency: request to instr_valid is 1 cycle after imem_rvalid. Best-case throughput is 1 instruction per 3 cycles (FETCH, WAIT, HOLD).
- Unsolicited imem_rvalid in FETCH or HOLD is ignored.
- redirect_pc bits [1:0] are dropped silently; misalignment is not flagged.

Decomposition:
- Shared package/include holds:
  - State encodings: FS_FETCH=2'd0, FS_WAIT=2'd1, FS_HOLD=2'd2, FS_DRAIN=2'd3.
  - RESET_PC default constant, next to the existing NPC op codes in ctrl_encode_def.
- No sub-module. The PC register, FSM and counter live in one module. The existing next-PC adder logic stays external and drives redirect_*.

Test Plan:
- Reset then free-run, memory grants immediately and returns rvalid next cycle, out_ready=1:
  - imem_addr sequence is 0x3000, 0x3004, 0x3008.
  - instr_pc matches each address, and fetch_cnt=3 after the third handoff.
- Redirect in WAIT to 0x0000_4001, rvalid two cycles later with 0xDEADBEEF:
  - The data is dropped and instr_valid stays 0.
  - The next request has imem_addr=0x4000.
- Redirect coincident with rvalid in WAIT, target 0x5000: no instr_valid pulse, and the next request is issued with imem_addr=0x5000.
- HOLD with out_ready=0 for 4 cycles, then stall=1 with out_ready=1 for 2 cycles:
  - instr and instr_pc stay stable, instr_valid=1, no new imem_req, fetch_cnt unchanged.
  - Release: fetch_cnt increments by exactly 1.
- pc=0xFFFF_FFFC fetched and accepted: the next imem_addr is 0x0000_0000 (wrap).
- Assert rst in WAIT and in HOLD: the next cycle shows instr_valid=0, pc=0x3000, fetch_cnt=0, and imem_req=1 the cycle after rst deasserts.
